// File: rtl/ring_pe_port.sv
// Ring-network PE port: two-VC injection toward cw/ccw links and
// two-VC ejection to the PE, phased by a free-running polarity bit.
module ring_pe_port (
    input  logic        clk,
    input  logic        reset,
    output logic        polarity,
    input  logic        pesi,
    output logic        peri,
    input  logic [63:0] pedi,
    output logic        cwso,
    input  logic        cwri,
    output logic [63:0] cwdo,
    output logic        ccwso,
    input  logic        ccwri,
    output logic [63:0] ccwdo,
    input  logic        ejsi,
    output logic        ejri,
    input  logic [63:0] ejdi,
    output logic        peso,
    input  logic        pero,
    output logic [63:0] pedo
);

    logic             pol_q;
    logic [1:0]       ifull_q, ifull_d;
    logic [1:0][63:0] ibuf_q, ibuf_d;
    logic [1:0]       efull_q, efull_d;
    logic [1:0][63:0] ebuf_q, ebuf_d;
    logic             rr_q, rr_d;

    logic        isel;
    logic        isend;
    logic [63:0] ipkt;
    logic [63:0] idata;
    logic        isend_done;
    logic        inj_keep;
    logic        eslot;
    logic        ej_acc;
    logic        esel;
    logic        deliver;
    logic        unused_vc;

    assign polarity = pol_q;

    // The VC not currently owned by the link phase is the only one allowed out.
    assign isel  = ~pol_q;
    assign isend = ifull_q[isel];
    assign ipkt  = ibuf_q[isel];
    assign idata = {ipkt[63:56], ipkt[55:48] >> 1, ipkt[47:0]};

    assign cwso  = isend & ~ipkt[62];
    assign ccwso = isend & ipkt[62];
    assign cwdo  = cwso ? idata : 64'd0;
    assign ccwdo = ccwso ? idata : 64'd0;

    assign isend_done = (cwso & cwri) | (ccwso & ccwri);

    assign peri     = ~ifull_q[pol_q];
    assign inj_keep = pesi & peri & (|pedi[55:48]);

    assign eslot  = ~pol_q;
    assign ejri   = ~efull_q[eslot];
    assign ej_acc = ejsi & ejri;

    assign peso    = |efull_q;
    assign esel    = efull_q[rr_q] ? rr_q : ~rr_q;
    assign pedo    = peso ? ebuf_q[esel] : 64'd0;
    assign deliver = peso & pero;

    assign unused_vc = pedi[63] ^ ejdi[63];

    always_comb begin
        ifull_d = ifull_q;
        ibuf_d  = ibuf_q;
        efull_d = efull_q;
        ebuf_d  = ebuf_q;
        rr_d    = rr_q;
        if (isend_done) begin
            ifull_d[isel] = 1'b0;
        end
        if (inj_keep) begin
            ifull_d[pol_q] = 1'b1;
            ibuf_d[pol_q]  = {pol_q, pedi[62:0]};
        end
        if (ej_acc) begin
            efull_d[eslot] = 1'b1;
            ebuf_d[eslot]  = {eslot, ejdi[62:0]};
        end
        if (deliver) begin
            efull_d[esel] = 1'b0;
            rr_d          = ~esel;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pol_q   <= 1'b0;
            ifull_q <= '0;
            ibuf_q  <= '0;
            efull_q <= '0;
            ebuf_q  <= '0;
            rr_q    <= 1'b0;
        end else begin
            pol_q   <= ~pol_q;
            ifull_q <= ifull_d;
            ibuf_q  <= ibuf_d;
            efull_q <= efull_d;
            ebuf_q  <= ebuf_d;
            rr_q    <= rr_d;
        end
    end

endmodule
